multi_blink_controller: RTL

Multi-channel LED blink/burst generator; successor to the single-channel fixed-frequency blinker. A shared prescaler derives a slow tick from the board clock, and each of NUM_CHANNELS channels is independently programmed for OFF, ON, continuous BLINK, or a counted BURST with a per-channel half-period. The block sits between the top-level control logic (config writes) and the board LED pins.

---
 rtl/multi_blink_controller_if.sv | 16 +
 rtl/multi_blink_controller.sv | 132 +++++++++++++
 2 files changed

// File: rtl/multi_blink_controller_if.sv
// Configuration write port of the multi-channel blink controller: one-cycle
// strobe plus target channel, mode, half-period and burst count.
interface multi_blink_controller_if #(
  parameter int CH_W    = 2,
  parameter int HALF_W  = 10,
  parameter int COUNT_W = 8
);
  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [1:0]         cfg_mode;
  logic [HALF_W-1:0]  cfg_half;
  logic [COUNT_W-1:0] cfg_count;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_half, cfg_count);
  modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_half, cfg_count);
endinterface

// File: rtl/multi_blink_controller.sv
// Multi-channel LED blink/burst generator: a shared prescaler tick drives
// per-channel OFF/ON/BLINK/BURST state machines programmed through cfg writes.
module multi_blink_controller #(
  parameter int  BASE_CLK     = 50000000,
  parameter int  TICK_HZ      = 1000,
  parameter int  NUM_CHANNELS = 4,
  parameter int  HALF_W       = 10,
  parameter int  COUNT_W      = 8,
  localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  multi_blink_controller_if.slave cfg,
  output logic [NUM_CHANNELS-1:0] led_out,
  output logic [NUM_CHANNELS-1:0] busy,
  output logic [NUM_CHANNELS-1:0] done,
  output logic                    tick_out
);

  localparam int TICK_DIV = BASE_CLK / TICK_HZ;
  localparam int PS_W     = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  typedef struct packed {
    state_t             state;
    mode_t              mode;
    logic [HALF_W-1:0]  half;
    logic [COUNT_W-1:0] remaining;
    logic [HALF_W-1:0]  phase;
  } chan_t;

  logic [PS_W-1:0]         ps_cnt;
  logic                    tick;
  chan_t                   ch_q [NUM_CHANNELS];
  chan_t                   ch_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] done_d;

  // Holding the counter at 0 while stopped means the first tick after a
  // restart always lands a full TICK_DIV cycles later.
  assign tick     = start && (ps_cnt == PS_W'(TICK_DIV - 1));
  assign tick_out = tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_cnt <= '0;
    end else if (!start || tick) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  // NOTE: the per-channel register array is tiny, so every entry is reset;
  // a large storage array would normally be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) ch_q[c] <= '0;
      done <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) ch_q[c] <= ch_d[c];
      done <= done_d;
    end
  end

  // NOTE: every combinational output is given its hold value first, so no
  // path through the branches below can leave a latch behind.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      ch_d[c]   = ch_q[c];
      done_d[c] = 1'b0;
      // A write outranks a same-cycle segment end: no done, no decrement.
      if (cfg.cfg_we && (cfg.cfg_ch == CH_W'(c))) begin
        ch_d[c].mode      = mode_t'(cfg.cfg_mode);
        ch_d[c].half      = (cfg.cfg_half == '0) ? HALF_W'(1) : cfg.cfg_half;
        ch_d[c].remaining = cfg.cfg_count;
        ch_d[c].phase     = '0;
        case (mode_t'(cfg.cfg_mode))
          MODE_BLINK: ch_d[c].state = ST_HIGH;
          MODE_BURST: begin
            if (cfg.cfg_count != '0) begin
              ch_d[c].state = ST_HIGH;
            end else begin
              ch_d[c].state = ST_IDLE;
              done_d[c]     = 1'b1;
            end
          end
          default:    ch_d[c].state = ST_IDLE;
        endcase
      end else if (tick && (ch_q[c].state != ST_IDLE)) begin
        if (ch_q[c].phase == ch_q[c].half - HALF_W'(1)) begin
          ch_d[c].phase = '0;
          if (ch_q[c].state == ST_HIGH) begin
            ch_d[c].state = ST_LOW;
          end else if (ch_q[c].mode != MODE_BURST) begin
            ch_d[c].state = ST_HIGH;
          end else if (ch_q[c].remaining > COUNT_W'(1)) begin
            ch_d[c].remaining = ch_q[c].remaining - COUNT_W'(1);
            ch_d[c].state     = ST_HIGH;
          end else begin
            ch_d[c].state = ST_IDLE;
            ch_d[c].mode  = MODE_OFF;
            done_d[c]     = 1'b1;
          end
        end else begin
          ch_d[c].phase = ch_q[c].phase + HALF_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      led_out[c] = (ch_q[c].state == ST_HIGH) ||
                   ((ch_q[c].state == ST_IDLE) && (ch_q[c].mode == MODE_ON));
      busy[c]    = (ch_q[c].state == ST_HIGH) || (ch_q[c].state == ST_LOW);
    end
  end

endmodule
